lsu_mem_bridge: RTL and testbench

- Load/store bridge between the RV32I core's data-access request and the single-port, word-wide `memory` bus (`mem_addr`/`mem_wr_en`/`mem_wr_data`/`mem_rd_data`).
- Converts LB/LH/LW/LBU/LHU/SB/SH/SW requests into aligned word accesses.
- Performs read-modify-write for sub-word stores, sign/zero-extends loads, and flags misaligned or illegal accesses.
- One request in flight at a time.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_align.sv | 46 ++++
 rtl/lsu_mem_bridge.sv | 152 +++++++++++++++
 tb/tb_lsu_mem_bridge.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store bridge: funct3 encodings, the
// bridge state type and the access legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_WRITE,
    ST_RESP
  } state_t;

  // Returns 1 when the request is misaligned for its size, uses a reserved
  // funct3 code, or asks for an unsigned store (which RV32I does not have).
  function automatic logic access_fault(input logic [2:0] funct3,
                                        input logic [1:0] lane,
                                        input logic       is_store);
    logic fault;
    fault = 1'b0;
    case (funct3)
      F3_B:    fault = 1'b0;
      F3_BU:   fault = is_store;
      F3_H:    fault = lane[0];
      F3_HU:   fault = lane[0] | is_store;
      F3_W:    fault = (lane != 2'b00);
      default: fault = 1'b1;
    endcase
    return fault;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends a load from a memory word,
// and merges a byte/half store into a memory word (little-endian lanes).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [4:0]  w_shift;
  logic [31:0] w_shifted;
  logic [31:0] w_byte_mask;
  logic [31:0] w_half_mask;

  assign w_shift     = {i_lane, 3'b000};
  assign w_shifted   = i_word >> w_shift;
  assign w_byte_mask = 32'h0000_00FF << w_shift;
  assign w_half_mask = 32'h0000_FFFF << w_shift;

  // Load path: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here via
    // the default arm) so no latch is inferred.
    case (i_funct3)
      F3_B:    o_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_BU:   o_load = {24'h0, w_shifted[7:0]};
      F3_H:    o_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_HU:   o_load = {16'h0, w_shifted[15:0]};
      default: o_load = w_shifted;
    endcase
  end

  // Store path: replace only the addressed byte/half of the read word.
  always_comb begin
    case (i_funct3[1:0])
      2'b00:   o_merged = (i_word & ~w_byte_mask) | (32'(i_wdata[7:0]) << w_shift);
      2'b01:   o_merged = (i_word & ~w_half_mask) | (32'(i_wdata[15:0]) << w_shift);
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_bridge.sv
// Load/store bridge between the core data port and a word-wide single-port
// memory. One request in flight; sub-word stores use read-modify-write.
module lsu_mem_bridge
  import lsu_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_wr_en,
  output logic [XLEN-1:0] mem_wr_data,
  input  logic [XLEN-1:0] mem_rd_data
);

  localparam logic [7:0] CNT_INIT = 8'(RD_LATENCY);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_wdata;

  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic [31:0] r_mem_addr;
  logic        r_mem_wr_en;
  logic [31:0] r_mem_wr_data;

  logic [31:0] w_load;
  logic [31:0] w_merged;
  logic [31:0] w_req_word;

  assign w_req_word = {req_addr[31:2], 2'b00};

  lsu_align u_align (
    .i_word   (mem_rd_data),
    .i_lane   (r_addr[1:0]),
    .i_funct3 (r_funct3),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  // Request sequencer: all outputs are registered and change only at edges.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= 8'd0;
      r_addr        <= 32'd0;
      r_we          <= 1'b0;
      r_funct3      <= 3'd0;
      r_wdata       <= 32'd0;
      r_req_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= 32'd0;
      r_rsp_err     <= 1'b0;
      r_mem_addr    <= 32'd0;
      r_mem_wr_en   <= 1'b0;
      r_mem_wr_data <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_addr      <= req_addr;
            r_we        <= req_we;
            r_funct3    <= req_funct3;
            r_wdata     <= req_wdata;
            r_req_ready <= 1'b0;
            if (access_fault(req_funct3, req_addr[1:0], req_we)) begin
              // Errors never touch memory; answer straight away.
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= 32'd0;
            end else if (req_we && (req_funct3 == F3_W)) begin
              // Full-word store needs no read.
              r_state       <= ST_WRITE;
              r_mem_addr    <= w_req_word;
              r_mem_wr_en   <= 1'b1;
              r_mem_wr_data <= req_wdata;
            end else begin
              r_state    <= ST_RD_WAIT;
              r_cnt      <= CNT_INIT;
              r_mem_addr <= w_req_word;
            end
          end
        end

        ST_RD_WAIT: begin
          if (r_cnt == 8'd0) begin
            if (r_we) begin
              r_state       <= ST_WRITE;
              r_mem_wr_en   <= 1'b1;
              r_mem_wr_data <= w_merged;
            end else begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_load;
              r_mem_addr  <= 32'd0;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end

        ST_WRITE: begin
          r_state       <= ST_RESP;
          r_mem_wr_en   <= 1'b0;
          r_mem_wr_data <= 32'd0;
          r_mem_addr    <= 32'd0;
          r_rsp_valid   <= 1'b1;
          r_rsp_rdata   <= 32'd0;
        end

        ST_RESP: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 1'b0;
          r_rsp_rdata <= 32'd0;
          r_rsp_err   <= 1'b0;
          r_req_ready <= 1'b1;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign mem_addr    = r_mem_addr;
  assign mem_wr_en   = r_mem_wr_en;
  assign mem_wr_data = r_mem_wr_data;

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Self-checking bench for lsu_mem_bridge with a 1-cycle-latency memory model
// and a byte-array reference model of the load/store semantics.
module tb_lsu_mem_bridge;

  localparam int RD_LATENCY = 1;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  int checks;
  int failures;

  logic [31:0] mem [0:255];
  logic [7:0]  ref_bytes [0:1023];

  lsu_mem_bridge #(.RD_LATENCY(RD_LATENCY), .XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .mem_addr    (mem_addr),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: registered read (one edge after the address), write on strobe.
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr[9:2]] <= mem_wr_data;
    mem_rd_data <= mem[mem_addr[9:2]];
  end

  // ---------------- reference model ----------------
  function automatic logic model_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0:    return 1'b0;
      3'd4:    return we;
      3'd1:    return (a % 2) != 0;
      3'd5:    return we || ((a % 2) != 0);
      3'd2:    return (a % 4) != 0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [7:0] b0, b1, b2, b3;
    b0 = ref_bytes[a[9:0]];
    b1 = ref_bytes[(a[9:0] + 10'd1)];
    b2 = ref_bytes[(a[9:0] + 10'd2)];
    b3 = ref_bytes[(a[9:0] + 10'd3)];
    case (f3)
      3'd0:    return {{24{b0[7]}}, b0};
      3'd4:    return {24'h0, b0};
      3'd1:    return {{16{b1[7]}}, b1, b0};
      3'd5:    return {16'h0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  function automatic void model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) ref_bytes[a[9:0] + 10'(i)] = d[8*i +: 8];
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [9:0] w;
    w = {a[9:2], 2'b00};
    return {ref_bytes[w + 10'd3], ref_bytes[w + 10'd2], ref_bytes[w + 10'd1], ref_bytes[w]};
  endfunction

  function automatic int model_latency(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (model_fault(we, f3, a)) return 1;
    if (we && f3 == 3'd2)        return 2;
    if (we)                      return RD_LATENCY + 3;
    return RD_LATENCY + 2;
  endfunction

  // ---------------- driver ----------------
  // Issues one request and observes it until its response (bounded).
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] rdata,
                        output logic err, output int wr_cnt, output logic [31:0] wr_addr,
                        output logic [31:0] wr_data);
    lat = -1; rdata = 32'hx; err = 1'bx; wr_cnt = 0; wr_addr = 32'h0; wr_data = 32'h0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (mem_wr_en) begin
        wr_cnt++; wr_addr = mem_addr; wr_data = mem_wr_data;
      end
      if (rsp_valid) begin
        lat = k; rdata = rsp_rdata; err = rsp_err;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++;
    if ({rsp_valid, rsp_err, mem_wr_en} !== 3'b000) begin
      failures++; $display("FAIL reset_strobes got=%b exp=000", {rsp_valid, rsp_err, mem_wr_en});
    end
    checks++;
    if ({rsp_rdata, mem_addr, mem_wr_data} !== 96'h0) begin
      failures++; $display("FAIL reset_buses rdata=%h addr=%h wdata=%h exp=0", rsp_rdata, mem_addr, mem_wr_data);
    end
    rst = 1'b1;
  endtask

  task automatic test_load_word();
    int lat, wc; logic [31:0] rd, wa, wd; logic er;
    do_req(1'b0, 3'd2, 32'h100, 32'h0, lat, rd, er, wc, wa, wd);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      failures++; $display("FAIL lw_data got=%h err=%b exp=deadbeef err=0", rd, er);
    end
    checks++;
    if (lat != 3) begin failures++; $display("FAIL lw_latency got=%0d exp=3", lat); end
    checks++;
    if (wc != 0) begin failures++; $display("FAIL lw_no_write got=%0d exp=0", wc); end
  endtask

  task automatic test_extension();
    logic [2:0]  f3s [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] ads [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
    logic [31:0] exp [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
    int lat, wc; logic [31:0] rd, wa, wd; logic er;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, f3s[i], ads[i], 32'h0, lat, rd, er, wc, wa, wd);
      checks++;
      if (rd !== exp[i] || er !== 1'b0 || lat != 3) begin
        failures++;
        $display("FAIL ext_%0d got=%h err=%b lat=%0d exp=%h err=0 lat=3", i, rd, er, lat, exp[i]);
      end
    end
  endtask

  task automatic test_store();
    int lat, wc; logic [31:0] rd, wa, wd; logic er;
    do_req(1'b1, 3'd0, 32'h101, 32'h12345677, lat, rd, er, wc, wa, wd);
    model_store(3'd0, 32'h101, 32'h12345677);
    checks++;
    if (wc != 1 || wd !== 32'hDEAD77EF || wa !== 32'h100) begin
      failures++; $display("FAIL sb_write cnt=%0d data=%h addr=%h exp=1 dead77ef 100", wc, wd, wa);
    end
    checks++;
    if (lat != 4 || er !== 1'b0 || rd !== 32'h0) begin
      failures++; $display("FAIL sb_resp lat=%0d err=%b rdata=%h exp=4 0 0", lat, er, rd);
    end
    checks++;
    if (mem[64] !== 32'hDEAD77EF) begin failures++; $display("FAIL sb_mem got=%h exp=dead77ef", mem[64]); end
    do_req(1'b1, 3'd2, 32'h100, 32'hCAFEF00D, lat, rd, er, wc, wa, wd);
    model_store(3'd2, 32'h100, 32'hCAFEF00D);
    checks++;
    if (lat != 2 || wc != 1 || er !== 1'b0) begin
      failures++; $display("FAIL sw_resp lat=%0d wr=%0d err=%b exp=2 1 0", lat, wc, er);
    end
    checks++;
    if (mem[64] !== 32'hCAFEF00D) begin failures++; $display("FAIL sw_mem got=%h exp=cafef00d", mem[64]); end
  endtask

  task automatic test_errors();
    logic        wes [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s [3] = '{3'd2, 3'd1, 3'd3};
    logic [31:0] ads [3] = '{32'h102, 32'h101, 32'h100};
    int lat, wc; logic [31:0] rd, wa, wd; logic er;
    for (int i = 0; i < 3; i++) begin
      do_req(wes[i], f3s[i], ads[i], 32'hFFFF_FFFF, lat, rd, er, wc, wa, wd);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0 || lat != 1 || wc != 0) begin
        failures++;
        $display("FAIL err_%0d err=%b rdata=%h lat=%0d wr=%0d exp=1 0 1 0", i, er, rd, lat, wc);
      end
    end
  endtask

  task automatic test_random();
    int lat, wc, elat; logic [31:0] rd, wa, wd, a, d, erd; logic er, we, ef; logic [2:0] f3;
    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        // Bias towards aligned addresses so most requests are legal.
        if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
        if (f3[1:0] == 2'd1) a[0] = 1'b0;
      end
      d  = $urandom;
      ef = model_fault(we, f3, a);
      erd = (we || ef) ? 32'h0 : model_load(f3, a);
      elat = model_latency(we, f3, a);
      do_req(we, f3, a, d, lat, rd, er, wc, wa, wd);
      if (we && !ef) model_store(f3, a, d);
      checks++;
      if (rd !== erd || er !== ef || lat != elat) begin
        failures++;
        $display("FAIL rand_%0d we=%b f3=%0d a=%h got=%h/%b/%0d exp=%h/%b/%0d",
                 n, we, f3, a, rd, er, lat, erd, ef, elat);
      end
      checks++;
      if ((we && !ef) ? (wc != 1 || wa !== {a[31:2], 2'b00} || wd !== model_word(a)) : (wc != 0)) begin
        failures++;
        $display("FAIL rand_wr_%0d cnt=%0d addr=%h data=%h exp_data=%h", n, wc, wa, wd, model_word(a));
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || req_ready !== 1'b1) begin
        failures++; $display("FAIL rand_idle_%0d valid=%b rdata=%h ready=%b exp=0 0 1", n, rsp_valid, rsp_rdata, req_ready);
      end
    end
    checks++;
    if (mem[64] !== model_word(32'h100)) begin
      failures++; $display("FAIL rand_mem got=%h exp=%h", mem[64], model_word(32'h100));
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, busy_bad; logic [31:0] rd1, rd2, e1, e2;
    lat1 = -1; lat2 = -1; busy_bad = 0; rd1 = 32'hx; rd2 = 32'hx;
    e1 = model_load(3'd2, 32'h200);
    e2 = model_load(3'd4, 32'h203);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h200; req_wdata = 32'h0;
    @(posedge clk);
    #1 req_funct3 = 3'd4; req_addr = 32'h203;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (req_ready !== 1'b0) busy_bad++;
      if (rsp_valid) begin lat1 = k; rd1 = rsp_rdata; break; end
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_idle ready=%b valid=%b exp=1 0", req_ready, rsp_valid);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (req_ready !== 1'b0) busy_bad++;
      if (rsp_valid) begin lat2 = k; rd2 = rsp_rdata; break; end
    end
    checks++;
    if (busy_bad != 0) begin failures++; $display("FAIL b2b_ready_busy got=%0d cycles exp=0", busy_bad); end
    checks++;
    if (rd1 !== e1 || lat1 != 3) begin failures++; $display("FAIL b2b_first got=%h lat=%0d exp=%h lat=3", rd1, lat1, e1); end
    checks++;
    if (rd2 !== e2 || lat2 != 3) begin failures++; $display("FAIL b2b_second got=%h lat=%0d exp=%h lat=3", rd2, lat2, e2); end
  endtask

  task automatic test_mid_reset();
    int lat, wc, stray; logic [31:0] rd, wa, wd; logic er;
    stray = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h100; req_wdata = 32'h0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || {rsp_valid, rsp_err, mem_wr_en} !== 3'b000 ||
        {rsp_rdata, mem_addr, mem_wr_data} !== 96'h0) begin
      failures++;
      $display("FAIL midrst_outputs ready=%b v=%b e=%b we=%b rdata=%h addr=%h exp=1 0 0 0 0 0",
               req_ready, rsp_valid, rsp_err, mem_wr_en, rsp_rdata, mem_addr);
    end
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) stray++;
    end
    checks++;
    if (stray != 0) begin failures++; $display("FAIL midrst_no_rsp got=%0d exp=0", stray); end
    do_req(1'b0, 3'd2, 32'h100, 32'h0, lat, rd, er, wc, wa, wd);
    checks++;
    if (rd !== model_word(32'h100) || lat != 3 || er !== 1'b0) begin
      failures++; $display("FAIL midrst_after got=%h lat=%0d exp=%h lat=3", rd, lat, model_word(32'h100));
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    rst = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[64] = 32'hDEADBEEF;
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 4; j++) ref_bytes[4*i + j] = mem[i][8*j +: 8];

    test_reset();
    test_load_word();
    test_extension();
    test_store();
    test_errors();
    test_random();
    test_back_to_back();
    test_mid_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
